serial_addsub: RTL and testbench
================================

// Module: serial_addsub
// PURPOSE
//  Multi-cycle, bit-serial add/subtract unit. It is the sequential, area-lean counterpart of the
//  rippleC_Nbit combinational adder. Operands are accepted over a valid/ready handshake.
//  DIGIT bits are resolved per clock, LSB first, with a registered carry between cycles.
//  A result port with valid/ready returns Sum, Cout and a signed-overflow flag.
//  Used where N-bit ripple depth would break timing and throughput needs are low.
// PARAMETERS
//  N      16  operand/result width; must be a multiple of DIGIT
//  DIGIT  1   bits processed per cycle; RUN length is N/DIGIT cycles
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      operand set valid
//  in_ready   out  1      unit can accept operands (high only in IDLE)
//  A          in   N      operand A, unsigned or two's complement
//  B          in   N      operand B
//  Cin        in   1      carry-in (add) / borrow-in (sub)
//  sub        in   1      0: A+B+Cin; 1: A-B-Cin
//  out_valid  out  1      result valid (high only in DONE)
//  out_ready  in   1      consumer accepts result
//  Sum        out  N      result, modulo 2^N
//  Cout       out  1      raw carry out of MSB (sub: 1 = no borrow)
//  ovf        out  1      signed overflow of the N-bit operation
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1, out_valid=0, Sum=0, Cout=0, ovf=0; all working regs cleared.
//  rst overrides every event in the same cycle, including a mid-RUN operation (it is abandoned) and a pending DONE.
//  FSM IDLE->RUN->DONE->IDLE:
//   IDLE: in_ready=1. On in_valid&&in_ready, latch:
//     opA=A; opB = sub ? ~B : B; carry = sub ? ~Cin : Cin; cnt=0.
//     Then go to RUN.
//   RUN: in_ready=0, out_valid=0. Each cycle:
//     Add the low DIGIT bits of opA and opB with carry.
//     Shift opA and opB right by DIGIT.
//     Shift the DIGIT result bits into the result reg from the MSB end.
//     Update carry; cnt++.
//     On the last digit (cnt==N/DIGIT-1), also capture carry-into-MSB for ovf.
//     Then go to DONE.
//   DONE: out_valid=1. Sum/Cout/ovf are registered and stable until the handshake.
//     On out_ready, go to IDLE.
//     If out_ready is held high, out_valid is a single-cycle pulse.
//  Latency: accept edge -> out_valid high N/DIGIT+1 edges later (N=16, DIGIT=1: 17).
//  Throughput: one op per N/DIGIT+2 cycles minimum. No overlap; in_ready stays low until DONE is consumed.
//  ovf = carry_into_MSB ^ Cout. Sub uses the inverted B and inverted Cin (two's complement).
//  Sum/Cout/ovf update only on the DONE entry edge and hold their last values in IDLE.
//  in_valid, A, B, Cin and sub are ignored outside IDLE. out_ready is ignored outside DONE.
//  Boundaries:
//   - cnt wraps only via its reset to 0 on accept.
//   - Add: all-ones + 1 gives Sum=0, Cout=1.
//   - Sub: 0 - 0 with Cin=0 gives Sum=0, Cout=1.
// STRUCTURE
//  Shared package addsub_pkg: state enum {IDLE,RUN,DONE}; localparam function for
//   count width = $clog2(N/DIGIT).
//  Sub-module: addsub_digit (DIGIT-bit ripple of full_adder cells). It is the only combinational datapath.
//  Top: FSM, operand shift regs, carry flop, counter, result regs.
// TESTING
//  1. A=12, B=238, Cin=0, sub=0 -> Sum=250, Cout=0, ovf=0; out_valid exactly 17 cycles after accept.
//  2. A=16'hFFFF, B=1, Cin=0, sub=0 -> Sum=0, Cout=1, ovf=0.
//  3. A=5, B=7, Cin=0, sub=1 -> Sum=16'hFFFE, Cout=0 (borrow).
//     Then A=13, B=240, Cin=1, sub=1 -> Sum=16'hFF1C, Cout=0.
//  4. A=16'h7FFF, B=1, sub=0 -> Sum=16'h8000, ovf=1.
//     Then A=16'h8000, B=1, sub=1 -> Sum=16'h7FFF, ovf=1.
//  5. Backpressure: hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0.
//     in_valid pulses during RUN/DONE are ignored.
//  6. Assert rst at RUN cycle 8 -> next edge: IDLE, in_ready=1, out_valid=0, Sum=0.
//     The following op (A=12, B=239) then yields 251.
//  Sweep A in 12..13, B in 238..244, Cin in {0,1}, both sub values, against a reference model.
//  Repeat with DIGIT=4.

Source files
------------

// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial add/subtract unit.
//   state_t     : control FSM states (IDLE -> RUN -> DONE -> IDLE)
//   cnt_width   : width of the digit counter for a given number of digit steps
//   full_adder  : one-bit full adder cell, returns {carry_out, sum}
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-step run still needs a one-bit counter so the vector stays legal.
  function automatic int cnt_width(input int steps);
    if (steps > 1) begin
      return $clog2(steps);
    end else begin
      return 1;
    end
  endfunction

  function automatic logic [1:0] full_adder(input logic a, input logic b, input logic c);
    logic s;
    logic co;
    s  = a ^ b ^ c;
    co = (a & b) | (a & c) | (b & c);
    return {co, s};
  endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// Operand / result handshake bundle of serial_addsub.
//   in_valid/in_ready   : operand transfer (A, B, Cin, sub)
//   out_valid/out_ready : result transfer (Sum, Cout, ovf)
//   master : producer of operands / consumer of results
//   slave  : the arithmetic unit
interface serial_addsub_if #(
  parameter int N = 16
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] Sum;
  logic         Cout;
  logic         ovf;

  modport master (
    output in_valid, A, B, Cin, sub, out_ready,
    input  in_ready, out_valid, Sum, Cout, ovf
  );

  modport slave (
    input  in_valid, A, B, Cin, sub, out_ready,
    output in_ready, out_valid, Sum, Cout, ovf
  );
endinterface

// File: rtl/serial_addsub_digit.sv
// DIGIT-bit ripple adder built from full_adder cells; the only
// combinational datapath of the serial unit.
//   a, b  : operand digits (b already inverted for subtraction)
//   cin   : carry into bit 0
//   sum   : digit result
//   cout  : carry out of the top bit of the digit
//   cmsb  : carry into the top bit of the digit (feeds signed overflow)
module serial_addsub_digit
  import serial_addsub_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic       c_s;
  logic [1:0] fa_s;

  // Ripple the carry through the digit; cmsb is left holding the carry
  // that entered the last cell.
  always_comb begin
    c_s  = cin;
    cmsb = cin;
    fa_s = 2'b00;
    sum  = {DIGIT{1'b0}};
    for (int i = 0; i < DIGIT; i++) begin
      cmsb   = c_s;
      fa_s   = full_adder(a[i], b[i], c_s);
      sum[i] = fa_s[0];
      c_s    = fa_s[1];
    end
    cout = c_s;
  end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract unit: N-bit operands are resolved DIGIT bits per
// clock, LSB first, with the carry held in a flop between cycles.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (abandons any operation)
//   bus  : serial_addsub_if.slave
//            operands A, B, Cin, sub accepted on in_valid && in_ready (IDLE only)
//            result Sum, Cout, ovf presented with out_valid (DONE only)
// sub=0 computes A+B+Cin; sub=1 computes A-B-Cin as A+~B+~Cin, so Cout=1
// means "no borrow". ovf is carry-into-MSB xor carry-out-of-MSB.
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int N     = 16,
  parameter int DIGIT = 1
) (
  input  logic           clk,
  input  logic           rst,
  serial_addsub_if.slave bus
);

  localparam int STEPS = N / DIGIT;
  localparam int CW    = cnt_width(STEPS);

  state_t           state_r;
  state_t           state_s;
  logic [N-1:0]     opa_r;
  logic [N-1:0]     opb_r;
  logic [N-1:0]     res_r;
  logic [N-1:0]     sum_r;
  logic             carry_r;
  logic             cout_r;
  logic             ovf_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic [CW-1:0]    cnt_r;

  logic             accept_s;
  logic             last_s;
  logic [DIGIT-1:0] dsum_s;
  logic             dcout_s;
  logic             dcmsb_s;
  logic [N-1:0]     res_next_s;

  serial_addsub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .a    (opa_r[DIGIT-1:0]),
    .b    (opb_r[DIGIT-1:0]),
    .cin  (carry_r),
    .sum  (dsum_s),
    .cout (dcout_s),
    .cmsb (dcmsb_s)
  );

  assign accept_s = (state_r == IDLE) && bus.in_valid;
  assign last_s   = (cnt_r == CW'(STEPS - 1));

  // New digit enters at the MSB end; after STEPS shifts the LSB digit has
  // travelled down to bit 0.
  assign res_next_s = (res_r >> DIGIT) | (N'(dsum_s) << (N - DIGIT));

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: RUN lasts exactly STEPS cycles, DONE waits for out_ready.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.in_valid) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Handshake flags registered from the next state so they are glitch-free.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
    end else begin
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
    end
  end

  // Operand shift registers, carry flop, digit counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_r   <= {N{1'b0}};
      opb_r   <= {N{1'b0}};
      res_r   <= {N{1'b0}};
      carry_r <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      sum_r   <= {N{1'b0}};
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            opa_r   <= bus.A;
            opb_r   <= bus.sub ? ~bus.B : bus.B;
            carry_r <= bus.sub ? ~bus.Cin : bus.Cin;
            res_r   <= {N{1'b0}};
            cnt_r   <= {CW{1'b0}};
          end
        end
        RUN: begin
          opa_r   <= opa_r >> DIGIT;
          opb_r   <= opb_r >> DIGIT;
          res_r   <= res_next_s;
          carry_r <= dcout_s;
          cnt_r   <= cnt_r + CW'(1);
          // Published results change only on the edge that enters DONE.
          if (last_s) begin
            sum_r  <= res_next_s;
            cout_r <= dcout_s;
            ovf_r  <= dcmsb_s ^ dcout_s;
          end
        end
        DONE: begin
          cnt_r <= cnt_r;
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.Sum       = sum_r;
  assign bus.Cout      = cout_r;
  assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_serial_addsub.sv
// Self-checking bench: two units (DIGIT=1 and DIGIT=4, N=16) driven with the
// same operands. Expected results are pushed to per-unit queues when an
// operand set is issued and popped by monitors on each result handshake.
module tb_serial_addsub;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  serial_addsub_if #(.N(16)) b1 ();
  serial_addsub_if #(.N(16)) b4 ();

  serial_addsub #(.N(16), .DIGIT(1)) u1 (.clk(clk), .rst(rst), .bus(b1));
  serial_addsub #(.N(16), .DIGIT(4)) u4 (.clk(clk), .rst(rst), .bus(b4));

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    res_t        exp;
  } vec_t;

  res_t q1[$];
  res_t q4[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Word-level reference using integer arithmetic.
  function automatic res_t ref_op(input logic [15:0] a, input logic [15:0] b,
                                  input logic cin, input logic sub);
    res_t r;
    int   ut;
    int   st;
    if (sub) begin
      ut = int'(a) - int'(b) - int'(cin);
      st = int'($signed(a)) - int'($signed(b)) - int'(cin);
      r.cout = (ut >= 0);
    end else begin
      ut = int'(a) + int'(b) + int'(cin);
      st = int'($signed(a)) + int'($signed(b)) + int'(cin);
      r.cout = (ut > 65535);
    end
    r.sum = ut[15:0];
    r.ovf = (st > 32767) || (st < -32768);
    return r;
  endfunction

  task automatic drive(input logic v, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic sub);
    b1.in_valid = v; b1.A = a; b1.B = b; b1.Cin = cin; b1.sub = sub;
    b4.in_valid = v; b4.A = a; b4.B = b; b4.Cin = cin; b4.sub = sub;
  endtask

  task automatic set_ready(input logic r);
    b1.out_ready = r;
    b4.out_ready = r;
  endtask

  // Result monitors.
  always @(negedge clk) begin
    res_t e;
    if (!rst && b1.out_valid && b1.out_ready) begin
      if (q1.size() == 0) begin
        chk("sb1_unexpected_result", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        chk("sb1_sum", 32'(b1.Sum), 32'(e.sum));
        chk("sb1_cout", 32'(b1.Cout), 32'(e.cout));
        chk("sb1_ovf", 32'(b1.ovf), 32'(e.ovf));
      end
    end
  end

  always @(negedge clk) begin
    res_t e;
    if (!rst && b4.out_valid && b4.out_ready) begin
      if (q4.size() == 0) begin
        chk("sb4_unexpected_result", 32'd1, 32'd0);
      end else begin
        e = q4.pop_front();
        chk("sb4_sum", 32'(b4.Sum), 32'(e.sum));
        chk("sb4_cout", 32'(b4.Cout), 32'(e.cout));
        chk("sb4_ovf", 32'(b4.ovf), 32'(e.ovf));
      end
    end
  end

  // Issue one operation with out_ready high and measure latency. The accept
  // edge counts as edge 1, so out_valid is first seen at edge N/DIGIT+1.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                       input logic sub, input res_t e);
    int k;
    int lat1;
    int lat4;
    @(negedge clk);
    chk("in_ready1_before_op", 32'(b1.in_ready), 32'd1);
    chk("in_ready4_before_op", 32'(b4.in_ready), 32'd1);
    q1.push_back(e);
    q4.push_back(e);
    drive(1'b1, a, b, cin, sub);
    @(posedge clk);
    #1 drive(1'b0, a, b, cin, sub);
    k = 1; lat1 = 0; lat4 = 0;
    while ((lat1 == 0 || lat4 == 0) && k < 40) begin
      @(negedge clk);
      if (b1.out_valid && lat1 == 0) lat1 = k;
      if (b4.out_valid && lat4 == 0) lat4 = k;
      @(posedge clk);
      k++;
    end
    chk("latency_digit1", 32'(lat1), 32'd17);
    chk("latency_digit4", 32'(lat4), 32'd5);
  endtask

  vec_t tbl[8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t e;
    int   k;

    tbl[0] = '{16'd12,     16'd238,    1'b0, 1'b0, '{16'd250,    1'b0, 1'b0}};
    tbl[1] = '{16'hFFFF,   16'd1,      1'b0, 1'b0, '{16'h0000,   1'b1, 1'b0}};
    tbl[2] = '{16'd5,      16'd7,      1'b0, 1'b1, '{16'hFFFE,   1'b0, 1'b0}};
    tbl[3] = '{16'd13,     16'd240,    1'b1, 1'b1, '{16'hFF1C,   1'b0, 1'b0}};
    tbl[4] = '{16'h7FFF,   16'd1,      1'b0, 1'b0, '{16'h8000,   1'b0, 1'b1}};
    tbl[5] = '{16'h8000,   16'd1,      1'b0, 1'b1, '{16'h7FFF,   1'b1, 1'b1}};
    tbl[6] = '{16'h0000,   16'h0000,   1'b0, 1'b1, '{16'h0000,   1'b1, 1'b0}};
    tbl[7] = '{16'hFFFF,   16'hFFFF,   1'b1, 1'b0, '{16'hFFFF,   1'b1, 1'b0}};

    drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    set_ready(1'b1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready1", 32'(b1.in_ready), 32'd1);
    chk("rst_out_valid1", 32'(b1.out_valid), 32'd0);
    chk("rst_sum1", 32'(b1.Sum), 32'd0);
    chk("rst_cout1", 32'(b1.Cout), 32'd0);
    chk("rst_ovf1", 32'(b1.ovf), 32'd0);
    chk("rst_in_ready4", 32'(b4.in_ready), 32'd1);
    chk("rst_out_valid4", 32'(b4.out_valid), 32'd0);
    chk("rst_sum4", 32'(b4.Sum), 32'd0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub, tbl[i].exp);
    end

    // Backpressure: hold DONE for 10 cycles with stray in_valid pulses.
    e = '{16'd250, 1'b0, 1'b0};
    @(posedge clk);
    #1 set_ready(1'b0);
    @(negedge clk);
    q1.push_back(e);
    q4.push_back(e);
    drive(1'b1, 16'd12, 16'd238, 1'b0, 1'b0);
    @(posedge clk);
    #1 drive(1'b1, 16'h0999, 16'h0111, 1'b1, 1'b1);
    k = 0;
    while (!b1.out_valid && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk("bp_reached_done", 32'(b1.out_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid1", 32'(b1.out_valid), 32'd1);
      chk("bp_in_ready1", 32'(b1.in_ready), 32'd0);
      chk("bp_sum1", 32'(b1.Sum), 32'd250);
      chk("bp_out_valid4", 32'(b4.out_valid), 32'd1);
      chk("bp_sum4", 32'(b4.Sum), 32'd250);
    end
    @(posedge clk);
    #1 drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    set_ready(1'b1);
    @(posedge clk);

    // Reset mid-RUN (DIGIT=1 unit) while the DIGIT=4 unit sits in DONE.
    @(posedge clk);
    #1 set_ready(1'b0);
    @(negedge clk);
    drive(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0);
    @(posedge clk);
    #1 drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_in_ready1", 32'(b1.in_ready), 32'd1);
    chk("mid_rst_out_valid1", 32'(b1.out_valid), 32'd0);
    chk("mid_rst_sum1", 32'(b1.Sum), 32'd0);
    chk("mid_rst_in_ready4", 32'(b4.in_ready), 32'd1);
    chk("mid_rst_out_valid4", 32'(b4.out_valid), 32'd0);
    chk("mid_rst_sum4", 32'(b4.Sum), 32'd0);
    @(posedge clk);
    #1 set_ready(1'b1);
    do_op(16'd12, 16'd239, 1'b0, 1'b0, '{16'd251, 1'b0, 1'b0});

    // Sweep against the reference model
    for (int a = 12; a <= 13; a++) begin
      for (int b = 238; b <= 244; b++) begin
        for (int c = 0; c <= 1; c++) begin
          for (int s = 0; s <= 1; s++) begin
            do_op(16'(a), 16'(b), 1'(c), 1'(s), ref_op(16'(a), 16'(b), 1'(c), 1'(s)));
          end
        end
      end
    end

    repeat (3) @(negedge clk);
    chk("sb1_drained", 32'(q1.size()), 32'd0);
    chk("sb4_drained", 32'(q4.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
